noc_packet_injector: RTL and testbench



---
 rtl/noc_flit_pkg.sv | 18 +
 rtl/noc_flit_fifo.sv | 47 ++++
 rtl/noc_packet_injector.sv | 106 ++++++++++
 tb/tb_noc_packet_injector.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared flit encodings and injector state type for the NoC input port.
// Latency: n/a; backpressure: n/a.
package noc_flit_pkg;

    localparam int LEN_W = 12;

    localparam logic [2:0] FLIT_IDLE = 3'b000;
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } inj_state_t;

endpackage

// File: rtl/noc_flit_fifo.sv
// Show-ahead payload FIFO; head is valid the cycle after a write into an empty FIFO.
// Latency: 1 cycle write-to-head; backpressure: full blocks pushes, even with a same-cycle pop.
module noc_flit_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_packet_injector.sv
// Router input port: turns a descriptor plus buffered payload into head/body/tail flits.
// Latency: req one cycle after descriptor accept; backpressure: holds on grant loss, drops req when starved.
module noc_packet_injector
    import noc_flit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [LEN_W-1:0]  desc_length,
    input  logic [DATA_W-1:0] desc_header,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              req,
    input  logic              grant,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] flit_data,
    output logic              busy
);

    inj_state_t        state_q;
    inj_state_t        state_d;
    logic [LEN_W-1:0]  length_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [DATA_W-1:0] header_q;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              desc_acc;

    noc_flit_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign length   = length_q;
    assign busy     = (state_q != IDLE);
    assign desc_acc = desc_valid && desc_ready;

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        flit_id    = FLIT_IDLE;
        flit_data  = '0;
        desc_ready = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                desc_ready = 1'b1;
                if (desc_valid) state_d = HEADER;
            end
            HEADER: begin
                req       = 1'b1;
                flit_id   = FLIT_HEAD;
                flit_data = header_q;
                if (grant) state_d = (length_q == '0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                // An empty FIFO releases the arbiter rather than stalling it.
                req       = !fifo_empty;
                flit_id   = (remaining_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
                flit_data = fifo_head;
                if (!fifo_empty && grant) begin
                    pop = 1'b1;
                    if (remaining_q == LEN_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            length_q    <= '0;
            remaining_q <= '0;
            header_q    <= '0;
        end else begin
            state_q <= state_d;
            if (desc_acc) begin
                length_q    <= desc_length;
                remaining_q <= desc_length;
                header_q    <= desc_header;
            end else if (pop && remaining_q != '0) begin
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: flit sequencing, grant loss, starvation, FIFO limits, async reset.
module tb_noc_packet_injector;
    import noc_flit_pkg::*;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              desc_valid = 1'b0;
    logic              desc_ready;
    logic [LEN_W-1:0]  desc_length = '0;
    logic [DATA_W-1:0] desc_header = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              req;
    logic              grant = 1'b0;
    logic [2:0]        flit_id;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] flit_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    noc_packet_injector #(.DATA_W(DATA_W), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_length (desc_length),
        .desc_header (desc_header),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .req         (req),
        .grant       (grant),
        .flit_id     (flit_id),
        .length      (length),
        .flit_data   (flit_data),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with room in the FIFO; returns at a negedge.
    task automatic put_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic send_desc(input logic [LEN_W-1:0] len, input logic [31:0] hdr);
        chk("desc_ready_idle", 32'(desc_ready), 32'd1);
        chk("req_before_accept", 32'(req), 32'd0);
        desc_valid  = 1'b1;
        desc_length = len;
        desc_header = hdr;
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic expect_flit(input string tag, input logic r, input logic [2:0] id, input logic [31:0] d);
        chk({tag, "_req"}, 32'(req), 32'(r));
        chk({tag, "_id"}, 32'(flit_id), 32'(id));
        chk({tag, "_data"}, flit_data, d);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_desc_ready"}, 32'(desc_ready), 32'd1);
        chk({tag, "_req"}, 32'(req), 32'd0);
    endtask

    initial begin
        int k;
        int nw;

        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_flit_id", 32'(flit_id), 32'd0);
        chk("rst_length", 32'(length), 32'd0);
        chk("rst_flit_data", flit_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Three-word packet, grant held.
        grant = 1'b1;
        put_words(32'hA000_0001, 3);
        send_desc(12'd3, 32'hCAFE_0001);
        expect_flit("p1_head", 1'b1, FLIT_HEAD, 32'hCAFE_0001);
        chk("p1_len_head", 32'(length), 32'd3);
        chk("p1_desc_ready_busy", 32'(desc_ready), 32'd0);
        @(negedge clk);
        expect_flit("p1_body1", 1'b1, FLIT_BODY, 32'hA000_0001);
        @(negedge clk);
        expect_flit("p1_body2", 1'b1, FLIT_BODY, 32'hA000_0002);
        chk("p1_len_body", 32'(length), 32'd3);
        @(negedge clk);
        expect_flit("p1_tail", 1'b1, FLIT_TAIL, 32'hA000_0003);
        @(negedge clk);
        expect_idle("p1_end");

        // Header-only packet leaves a preloaded word in place.
        put_words(32'hB000_0001, 1);
        send_desc(12'd0, 32'hCAFE_0002);
        expect_flit("p2_head", 1'b1, FLIT_HEAD, 32'hCAFE_0002);
        @(negedge clk);
        expect_idle("p2_end");
        chk("p2_flit_id_idle", 32'(flit_id), 32'd0);

        // Length 4 with a five-cycle grant loss before the third payload flit.
        put_words(32'hB000_0002, 3);
        send_desc(12'd4, 32'hCAFE_0003);
        expect_flit("p3_head", 1'b1, FLIT_HEAD, 32'hCAFE_0003);
        @(negedge clk);
        expect_flit("p3_body1", 1'b1, FLIT_BODY, 32'hB000_0001);
        @(negedge clk);
        expect_flit("p3_body2", 1'b1, FLIT_BODY, 32'hB000_0002);
        @(negedge clk);
        grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_flit("p3_frozen", 1'b1, FLIT_BODY, 32'hB000_0003);
            chk("p3_frozen_len", 32'(length), 32'd4);
            @(negedge clk);
        end
        grant = 1'b1;
        expect_flit("p3_regrant_body", 1'b1, FLIT_BODY, 32'hB000_0003);
        @(negedge clk);
        expect_flit("p3_tail", 1'b1, FLIT_TAIL, 32'hB000_0004);
        @(negedge clk);
        expect_idle("p3_end");

        // Starvation: length 2 with only one word buffered.
        put_words(32'hC000_0001, 1);
        send_desc(12'd2, 32'hCAFE_0004);
        expect_flit("p4_head", 1'b1, FLIT_HEAD, 32'hCAFE_0004);
        @(negedge clk);
        expect_flit("p4_body", 1'b1, FLIT_BODY, 32'hC000_0001);
        @(negedge clk);
        chk("p4_starved_req", 32'(req), 32'd0);
        chk("p4_starved_id", 32'(flit_id), 32'(FLIT_TAIL));
        chk("p4_starved_busy", 32'(busy), 32'd1);
        put_words(32'hC000_0002, 1);
        expect_flit("p4_tail", 1'b1, FLIT_TAIL, 32'hC000_0002);
        @(negedge clk);
        expect_idle("p4_end");

        // FIFO full, dropped write, and ordering across pointer wrap.
        grant = 1'b0;
        put_words(32'hD000_0000, 8);
        chk("fifo_full_wr_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("full_drop_wr_ready", 32'(wr_ready), 32'd0);
        grant = 1'b1;
        send_desc(12'd20, 32'hCAFE_0005);
        expect_flit("p5_head", 1'b1, FLIT_HEAD, 32'hCAFE_0005);
        @(negedge clk);
        chk("p5_no_pop_wr_ready", 32'(wr_ready), 32'd0);
        k  = 0;
        nw = 8;
        for (int cyc = 0; cyc < 80 && k < 20; cyc++) begin
            if (cyc == 1) chk("p5_pop_raises_wr_ready", 32'(wr_ready), 32'd1);
            if (req) begin
                chk("p5_wrap_data", flit_data, 32'hD000_0000 + 32'(k));
                chk("p5_wrap_id", 32'(flit_id), (k == 19) ? 32'(FLIT_TAIL) : 32'(FLIT_BODY));
                k++;
            end
            if (wr_ready && nw < 20) begin
                wr_valid = 1'b1;
                wr_data  = 32'hD000_0000 + 32'(nw);
                nw++;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("p5_flit_count", 32'(k), 32'd20);
        expect_idle("p5_end");

        // Asynchronous reset in the middle of a payload.
        put_words(32'hE000_0000, 2);
        send_desc(12'd4, 32'hCAFE_0006);
        expect_flit("p6_head", 1'b1, FLIT_HEAD, 32'hCAFE_0006);
        @(negedge clk);
        expect_flit("p6_body", 1'b1, FLIT_BODY, 32'hE000_0000);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(req), 32'd0);
        chk("arst_flit_id", 32'(flit_id), 32'd0);
        chk("arst_length", 32'(length), 32'd0);
        chk("arst_flit_data", flit_data, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_desc(12'd1, 32'hCAFE_0007);
        expect_flit("p7_head", 1'b1, FLIT_HEAD, 32'hCAFE_0007);
        @(negedge clk);
        chk("p7_fifo_empty_req", 32'(req), 32'd0);
        chk("p7_busy", 32'(busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
